// File: rtl/even_div_pkg.sv
// Shared types and helpers for the runtime-programmable even clock divider.
package even_div_pkg;

    localparam int CNT_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2,
        STOP = 2'd3
    } div_state_t;

    // Half-period count for an even divide ratio.
    function automatic int half_of(input int div);
        return div / 2;
    endfunction

endpackage

// File: rtl/div_half_cnt.sv
// Half-period counter and divided-clock toggle register for the even divider.
// Produces a 50% duty clk_out with 'half' clk cycles per phase and flags the
// last cycle of each full period.
module div_half_cnt
    import even_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] half,
    output logic [CNT_W-1:0] cnt,
    output logic             clk_out,
    output logic             pe
);

    logic last;

    assign last = (cnt == (half - CNT_W'(1)));
    assign pe   = run && clk_out && last;

    // Count through each half period and toggle clk_out on its last cycle; load parks both at zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (load) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (run) begin
            if (last) begin
                cnt     <= '0;
                clk_out <= ~clk_out;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/even_div_ctrl.sv
// Controller for the even clock divider: accepts new half-period values over a
// valid/ready handshake and applies them only on full-period boundaries, and
// sequences enable/disable so clk_out never shows a runt phase.
module even_div_ctrl
    import even_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int DEFAULT_DIV = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             busy,
    output logic [CNT_W-1:0] cur_half,
    output logic             period_tick,
    output logic             switch_done,
    output logic             err
);

    localparam logic [CNT_W-1:0] RESET_HALF = CNT_W'(half_of(DEFAULT_DIV));

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cur_half_q, cur_half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             err_q, err_d;
    logic             switch_done_q, switch_done_d;

    logic             run;
    logic             load;
    logic             pe;
    logic             accept;
    logic             cfg_zero;
    logic [CNT_W-1:0] cnt_unused;

    assign cfg_ready   = (state_q == OFF) || (state_q == RUN);
    assign accept      = cfg_valid && cfg_ready;
    assign cfg_zero    = (cfg_half == '0);
    assign run         = (state_q != OFF);
    assign busy        = (state_q != OFF);
    assign cur_half    = cur_half_q;
    assign period_tick = pe;
    assign switch_done = switch_done_q;
    assign err         = err_q;

    div_half_cnt #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .run     (run),
        .load    (load),
        .half    (cur_half_q),
        .cnt     (cnt_unused),
        .clk_out (clk_out),
        .pe      (pe)
    );

    // State, active ratio, pending ratio and the registered pulse outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= OFF;
            cur_half_q    <= RESET_HALF;
            pend_half_q   <= '0;
            err_q         <= 1'b0;
            switch_done_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_half_q    <= cur_half_d;
            pend_half_q   <= pend_half_d;
            err_q         <= err_d;
            switch_done_q <= switch_done_d;
        end
    end

    // Next-state logic; a pending ratio is marked by a non-zero pend_half since zero is never legal.
    always_comb begin
        state_d       = state_q;
        cur_half_d    = cur_half_q;
        pend_half_d   = pend_half_q;
        err_d         = 1'b0;
        switch_done_d = 1'b0;
        load          = 1'b0;

        if (accept && cfg_zero) begin
            err_d = 1'b1;
        end

        case (state_q)
            OFF: begin
                if (accept && !cfg_zero) begin
                    cur_half_d = cfg_half;
                end
                if (en) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && !cfg_zero && (cfg_half != cur_half_q)) begin
                    pend_half_d = cfg_half;
                    state_d     = PEND;
                end
                if (!en) begin
                    state_d = STOP;
                end
            end
            PEND: begin
                if (pe) begin
                    cur_half_d    = pend_half_q;
                    pend_half_d   = '0;
                    load          = 1'b1;
                    switch_done_d = 1'b1;
                    state_d       = en ? RUN : STOP;
                end else if (!en) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (pe) begin
                    load    = 1'b1;
                    state_d = OFF;
                    if (pend_half_q != '0) begin
                        cur_half_d    = pend_half_q;
                        pend_half_d   = '0;
                        switch_done_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = OFF;
            end
        endcase
    end

endmodule

// File: tb/tb_even_div_ctrl.sv
// Self-checking bench for even_div_ctrl: a reset/default-run vector table plus
// hand-written sequences for ratio switching, illegal configs, disable and reset.
module tb_even_div_ctrl;

    typedef struct {
        logic       clk_out;
        logic       busy;
        logic       cfg_ready;
        logic       period_tick;
        logic       switch_done;
        logic       err;
        logic [7:0] cur_half;
    } exp_t;

    typedef struct {
        logic       rstn;
        logic       en;
        logic       cfg_valid;
        logic [7:0] cfg_half;
        exp_t       exp_v;
    } vec_t;

    logic       clk;
    logic       rstn;
    logic       en;
    logic       cfg_valid;
    logic [7:0] cfg_half;
    logic       cfg_ready;
    logic       clk_out;
    logic       busy;
    logic [7:0] cur_half;
    logic       period_tick;
    logic       switch_done;
    logic       err;

    int   checks;
    int   errors;
    int   step_no;
    exp_t exp_q[$];
    vec_t tbl[25];

    even_div_ctrl #(
        .CNT_W       (8),
        .DEFAULT_DIV (10)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .cfg_valid   (cfg_valid),
        .cfg_half    (cfg_half),
        .cfg_ready   (cfg_ready),
        .clk_out     (clk_out),
        .busy        (busy),
        .cur_half    (cur_half),
        .period_tick (period_tick),
        .switch_done (switch_done),
        .err         (err)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk_exp(input logic co, input logic bsy, input logic rdy,
                                    input logic tick, input logic sd, input logic er,
                                    input logic [7:0] ch);
        exp_t e;
        e.clk_out     = co;
        e.busy        = bsy;
        e.cfg_ready   = rdy;
        e.period_tick = tick;
        e.switch_done = sd;
        e.err         = er;
        e.cur_half    = ch;
        return e;
    endfunction

    // Expected outputs s cycles after the counter started a fresh period with half h.
    function automatic exp_t run_exp(input int h, input int s, input logic bsy,
                                     input logic rdy, input logic sd, input logic er);
        int p;
        p = s % (2 * h);
        return mk_exp((p >= h), bsy, rdy, (p == 2 * h - 1), sd, er, 8'(h));
    endfunction

    function automatic vec_t mk_vec(input logic r, input logic e, input logic cv,
                                    input logic [7:0] ch, input exp_t ex);
        vec_t v;
        v.rstn      = r;
        v.en        = e;
        v.cfg_valid = cv;
        v.cfg_half  = ch;
        v.exp_v     = ex;
        return v;
    endfunction

    task automatic check_field(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL step %0d %s: got %0d expected %0d", step_no, name, act, expv);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        e = exp_q.pop_front();
        check_field("clk_out",     8'(clk_out),     8'(e.clk_out));
        check_field("busy",        8'(busy),        8'(e.busy));
        check_field("cfg_ready",   8'(cfg_ready),   8'(e.cfg_ready));
        check_field("period_tick", 8'(period_tick), 8'(e.period_tick));
        check_field("switch_done", 8'(switch_done), 8'(e.switch_done));
        check_field("err",         8'(err),         8'(e.err));
        check_field("cur_half",    cur_half,        e.cur_half);
    endtask

    // Drive one cycle of inputs, record its expectation, and compare after the edge.
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        rstn      = v.rstn;
        en        = v.en;
        cfg_valid = v.cfg_valid;
        cfg_half  = v.cfg_half;
        exp_q.push_back(v.exp_v);
        @(posedge clk);
        #1;
        step_no++;
        checkOutput();
    endtask

    task automatic step(input logic en_i, input logic cv_i, input logic [7:0] ch_i, input exp_t e);
        applyStimulus(mk_vec(1'b1, en_i, cv_i, ch_i, e));
    endtask

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t off5;
        int   idx;

        checks    = 0;
        errors    = 0;
        step_no   = 0;
        rstn      = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_half  = 8'd0;
        off5      = mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd5);

        // Reset, idle OFF, then the default 5/5 waveform.
        idx = 0;
        for (int i = 0; i < 3; i++) begin
            tbl[idx] = mk_vec(1'b0, 1'b0, 1'b0, 8'd0, off5);
            idx++;
        end
        for (int i = 0; i < 2; i++) begin
            tbl[idx] = mk_vec(1'b1, 1'b0, 1'b0, 8'd0, off5);
            idx++;
        end
        for (int s = 0; s < 20; s++) begin
            tbl[idx] = mk_vec(1'b1, 1'b1, 1'b0, 8'd0, run_exp(5, s, 1'b1, 1'b1, 1'b0, 1'b0));
            idx++;
        end
        for (int i = 0; i < 25; i++) begin
            applyStimulus(tbl[i]);
        end

        // Illegal cfg_half=0 in RUN: err pulse only, waveform undisturbed.
        for (int s = 20; s <= 29; s++) begin
            step(1'b1, (s == 22), 8'd0, run_exp(5, s, 1'b1, 1'b1, 1'b0, (s == 22)));
        end

        // Disable during the first low cycle: finish the period, then OFF.
        step(1'b1, 1'b0, 8'd0, run_exp(5, 30, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int s = 31; s <= 39; s++) begin
            step(1'b0, 1'b0, 8'd0, run_exp(5, s, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 8'd0, off5);
        end

        // Re-enable and switch to half=2 on the second high cycle.
        for (int s = 0; s <= 6; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(5, s, 1'b1, 1'b1, 1'b0, 1'b0));
        end
        step(1'b1, 1'b1, 8'd2, run_exp(5, 7, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int s = 8; s <= 9; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(5, s, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        for (int s = 0; s <= 7; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(2, s, 1'b1, 1'b1, (s == 0), 1'b0));
        end

        // Requesting the ratio already in effect is a no-op.
        step(1'b1, 1'b1, 8'd2, run_exp(2, 8, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int s = 9; s <= 12; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(2, s, 1'b1, 1'b1, 1'b0, 1'b0));
        end

        // New ratio and disable in the same RUN cycle: applied at the STOP boundary.
        step(1'b0, 1'b1, 8'd3, run_exp(2, 13, 1'b1, 1'b0, 1'b0, 1'b0));
        for (int s = 14; s <= 15; s++) begin
            step(1'b0, 1'b0, 8'd0, run_exp(2, s, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 8'd0, mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd3));
        step(1'b0, 1'b0, 8'd0, mk_exp(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd3));

        // Re-enable with the 3/3 waveform.
        for (int s = 0; s <= 12; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(3, s, 1'b1, 1'b1, 1'b0, 1'b0));
        end

        // Reset while a ratio is pending: defaults return and the pending ratio is lost.
        step(1'b1, 1'b1, 8'd7, run_exp(3, 13, 1'b1, 1'b0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 8'd0, run_exp(3, 14, 1'b1, 1'b0, 1'b0, 1'b0));
        applyStimulus(mk_vec(1'b0, 1'b1, 1'b0, 8'd0, off5));
        step(1'b0, 1'b0, 8'd0, off5);
        for (int s = 0; s <= 11; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(5, s, 1'b1, 1'b1, 1'b0, 1'b0));
        end

        // Stop again, then load half=1 together with enable from OFF.
        for (int s = 12; s <= 19; s++) begin
            step(1'b0, 1'b0, 8'd0, run_exp(5, s, 1'b1, 1'b0, 1'b0, 1'b0));
        end
        step(1'b0, 1'b0, 8'd0, off5);
        step(1'b1, 1'b1, 8'd1, run_exp(1, 0, 1'b1, 1'b1, 1'b0, 1'b0));
        for (int s = 1; s <= 6; s++) begin
            step(1'b1, 1'b0, 8'd0, run_exp(1, s, 1'b1, 1'b1, 1'b0, 1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
